mi_ram_resp: RTL and testbench

//  Memory-side responder for the MiProcTop RAM port. Receives ARamAddr/ARamMosi/ARamWrEn/ARamRdEn,

---
 rtl/mi_ram_resp.sv | 167 ++++++++++++++++
 tb/tb_mi_ram_resp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mi_ram_resp.sv
// ============================================================================
// Module      : mi_ram_resp
// Description : Memory-side responder for the MiProcTop RAM port. It provides
//               byte-lane reads and writes and stalls the core for a
//               programmable number of wait states per access.
//               Optional build macro MI_RAM_RESP_INIT_EN: zero the array after
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mi_ram_resp #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000,
    parameter int          WAIT_CNT  = 1
) (
    input  logic        AClkH,
    input  logic        AResetHN,
    input  logic        AClkHEn,
    input  logic [28:0] ARamAddr,
    input  logic [63:0] ARamMosi,
    input  logic [7:0]  ARamWrEn,
    input  logic [7:0]  ARamRdEn,
    output logic [63:0] ARamMiso,
    output logic        AExecEn,
    output logic        AErr
);

    localparam int         C_DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] C_WAIT  = WAIT_CNT[3:0];

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef MI_RAM_RESP_INIT_EN
    localparam logic [1:0]           S_INIT = 2'd3;
    localparam logic [ADDR_BITS-1:0] C_LAST = '1;
`endif

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [28:0] r_addr;
    logic [63:0] r_mosi;
    logic [7:0]  r_wr;
    logic [7:0]  r_rd;
    logic        r_err;
    logic [63:0] r_miso;
    logic [63:0] r_mem [C_DEPTH];
`ifdef MI_RAM_RESP_INIT_EN
    logic [ADDR_BITS-1:0] r_init_ptr;
`endif

    logic        w_req;
    logic        w_exec;
    logic        w_in_win;
    logic [28:0] w_addr;
    logic [63:0] w_mosi;
    logic [7:0]  w_wr;
    logic [7:0]  w_rd;
    logic [63:0] w_old;
    logic [63:0] w_merged;
    logic [63:0] w_rdata;

    assign AExecEn  = (r_state == S_IDLE);
    assign AErr     = r_err;
    assign ARamMiso = r_miso;

    assign w_req = AExecEn & ((|ARamWrEn) | (|ARamRdEn));

    // With no wait states the access executes on the request edge itself,
    // so it uses the live inputs instead of the latched copy.
    assign w_addr = (WAIT_CNT == 0) ? ARamAddr : r_addr;
    assign w_mosi = (WAIT_CNT == 0) ? ARamMosi : r_mosi;
    assign w_wr   = (WAIT_CNT == 0) ? ARamWrEn : r_wr;
    assign w_rd   = (WAIT_CNT == 0) ? ARamRdEn : r_rd;
    assign w_exec = AClkHEn & ((WAIT_CNT == 0) ? w_req : (r_state == S_DONE));

    assign w_in_win = (w_addr[28:ADDR_BITS] == BASE_ADDR[31:3+ADDR_BITS]);
    assign w_old    = r_mem[w_addr[ADDR_BITS-1:0]];

    // Write-first merge: read lanes see the bytes written by the same access.
    always_comb begin
        w_merged = w_old;
        w_rdata  = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_wr[i]) begin
                w_merged[8*i +: 8] = w_mosi[8*i +: 8];
            end
            if (w_rd[i] && w_in_win) begin
                w_rdata[8*i +: 8] = w_merged[8*i +: 8];
            end
        end
    end

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
`ifdef MI_RAM_RESP_INIT_EN
            r_state    <= S_INIT;
            r_init_ptr <= '0;
`else
            r_state    <= S_IDLE;
`endif
            r_cnt  <= 4'd0;
            r_addr <= '0;
            r_mosi <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_err  <= 1'b0;
            r_miso <= '0;
        end else if (AClkHEn) begin
            r_err <= w_exec & ~w_in_win;
            if (w_exec && (|w_rd)) begin
                r_miso <= w_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req && (WAIT_CNT != 0)) begin
                        r_addr  <= ARamAddr;
                        r_mosi  <= ARamMosi;
                        r_wr    <= ARamWrEn;
                        r_rd    <= ARamRdEn;
                        r_cnt   <= 4'd1;
                        r_state <= (C_WAIT == 4'd1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // DONE is itself the last stall cycle, hence WAIT_CNT-1.
                    if (r_cnt >= (C_WAIT - 4'd1)) begin
                        r_state <= S_DONE;
                    end
                    if (r_cnt != 4'hF) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_cnt   <= 4'd0;
                    r_state <= S_IDLE;
                end
`ifdef MI_RAM_RESP_INIT_EN
                S_INIT: begin
                    r_init_ptr <= r_init_ptr + 1'b1;
                    if (r_init_ptr == C_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge AClkH) begin
        if (AResetHN && AClkHEn) begin
`ifdef MI_RAM_RESP_INIT_EN
            if (r_state == S_INIT) begin
                r_mem[r_init_ptr] <= '0;
            end else
`endif
            if (w_exec && w_in_win && (|w_wr)) begin
                r_mem[w_addr[ADDR_BITS-1:0]] <= w_merged;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mi_ram_resp.sv
// ============================================================================
// Module      : tb_mi_ram_resp
// Description : Directed self-checking bench for mi_ram_resp with zero, one and
//               three wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mi_ram_resp;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [28:0] addr;
    logic [63:0] mosi;
    logic [7:0]  wr0, rd0, wr1, rd1, wr3, rd3;
    logic [63:0] miso0, miso1, miso3;
    logic        exec0, exec1, exec3;
    logic        err0, err1, err3;

    int passed = 0;
    int total  = 0;

    mi_ram_resp #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_CNT(0)) dut0 (
        .AClkH(clk), .AResetHN(rst_n), .AClkHEn(clk_en), .ARamAddr(addr),
        .ARamMosi(mosi), .ARamWrEn(wr0), .ARamRdEn(rd0), .ARamMiso(miso0),
        .AExecEn(exec0), .AErr(err0)
    );

    mi_ram_resp #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_CNT(1)) dut1 (
        .AClkH(clk), .AResetHN(rst_n), .AClkHEn(clk_en), .ARamAddr(addr),
        .ARamMosi(mosi), .ARamWrEn(wr1), .ARamRdEn(rd1), .ARamMiso(miso1),
        .AExecEn(exec1), .AErr(err1)
    );

    mi_ram_resp #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_CNT(3)) dut3 (
        .AClkH(clk), .AResetHN(rst_n), .AClkHEn(clk_en), .ARamAddr(addr),
        .ARamMosi(mosi), .ARamWrEn(wr3), .ARamRdEn(rd3), .ARamMiso(miso3),
        .AExecEn(exec3), .AErr(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step(); step();
        total++; if (miso1 !== 64'h0) $display("FAIL reset_miso1: got %h expected %h", miso1, 64'h0); else passed++;
        total++; if (exec1 !== 1'b1) $display("FAIL reset_exec1: got %b expected 1", exec1); else passed++;
        total++; if (err1 !== 1'b0) $display("FAIL reset_err1: got %b expected 0", err1); else passed++;
        total++; if (exec0 !== 1'b1) $display("FAIL reset_exec0: got %b expected 1", exec0); else passed++;
        total++; if (exec3 !== 1'b1) $display("FAIL reset_exec3: got %b expected 1", exec3); else passed++;
        total++; if (miso3 !== 64'h0) $display("FAIL reset_miso3: got %h expected %h", miso3, 64'h0); else passed++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_word_rw();
        addr = 29'd5; mosi = 64'h1122334455667788; wr1 = 8'hFF;
        step();
        wr1 = 8'h00;
        total++; if (exec1 !== 1'b0) $display("FAIL t2_write_stall: got %b expected 0", exec1); else passed++;
        step();
        total++; if (exec1 !== 1'b1) $display("FAIL t2_write_release: got %b expected 1", exec1); else passed++;
        addr = 29'd5; mosi = 64'h0; rd1 = 8'hFF;
        step();
        rd1 = 8'h00;
        total++; if (exec1 !== 1'b0) $display("FAIL t2_read_stall: got %b expected 0", exec1); else passed++;
        step();
        total++; if (exec1 !== 1'b1) $display("FAIL t2_read_release: got %b expected 1", exec1); else passed++;
        total++; if (miso1 !== 64'h1122334455667788) $display("FAIL t2_read_data: got %h expected %h", miso1, 64'h1122334455667788); else passed++;
    endtask

    task automatic test_byte_lanes();
        addr = 29'd5; mosi = 64'hAAAAAAAAAAAAAAAA; wr1 = 8'h01;
        step();
        wr1 = 8'h00;
        step();
        total++; if (miso1 !== 64'h1122334455667788) $display("FAIL t3_write_keeps_miso: got %h expected %h", miso1, 64'h1122334455667788); else passed++;
        addr = 29'd5; rd1 = 8'h0F;
        step();
        rd1 = 8'h00;
        step();
        total++; if (miso1 !== 64'h00000000556677AA) $display("FAIL t3_lane_read: got %h expected %h", miso1, 64'h00000000556677AA); else passed++;
    endtask

    task automatic test_back_to_back();
        addr = 29'd7; mosi = 64'h0123456789ABCDEF; wr0 = 8'hFF; rd0 = 8'h00;
        step();
        total++; if (exec0 !== 1'b1) $display("FAIL t4_exec_c1: got %b expected 1", exec0); else passed++;
        addr = 29'd7; mosi = 64'h0; wr0 = 8'h00; rd0 = 8'hFF;
        step();
        total++; if (miso0 !== 64'h0123456789ABCDEF) $display("FAIL t4_read_c2: got %h expected %h", miso0, 64'h0123456789ABCDEF); else passed++;
        total++; if (exec0 !== 1'b1) $display("FAIL t4_exec_c2: got %b expected 1", exec0); else passed++;
        addr = 29'd7; mosi = 64'hFEDCBA9876543210; wr0 = 8'h0F; rd0 = 8'hFF;
        step();
        total++; if (miso0 !== 64'h0123456776543210) $display("FAIL t4_write_first: got %h expected %h", miso0, 64'h0123456776543210); else passed++;
        addr = 29'd8; mosi = 64'h5555AAAA33334444; wr0 = 8'hFF; rd0 = 8'h00;
        step();
        total++; if (miso0 !== 64'h0123456776543210) $display("FAIL t4_write_only_hold: got %h expected %h", miso0, 64'h0123456776543210); else passed++;
        total++; if (exec0 !== 1'b1) $display("FAIL t4_exec_c4: got %b expected 1", exec0); else passed++;
        addr = 29'd8; mosi = 64'h0; wr0 = 8'h00; rd0 = 8'hF0;
        step();
        rd0 = 8'h00;
        total++; if (miso0 !== 64'h5555AAAA00000000) $display("FAIL t4_upper_lanes: got %h expected %h", miso0, 64'h5555AAAA00000000); else passed++;
    endtask

    task automatic test_out_of_window();
        addr = 29'h1000_0005; mosi = 64'hFFFFFFFFFFFFFFFF; wr1 = 8'hFF; rd1 = 8'hFF;
        step();
        wr1 = 8'h00; rd1 = 8'h00;
        total++; if (exec1 !== 1'b0) $display("FAIL t5_stall: got %b expected 0", exec1); else passed++;
        total++; if (err1 !== 1'b0) $display("FAIL t5_err_early: got %b expected 0", err1); else passed++;
        step();
        total++; if (err1 !== 1'b1) $display("FAIL t5_err_pulse: got %b expected 1", err1); else passed++;
        total++; if (miso1 !== 64'h0) $display("FAIL t5_miso_zero: got %h expected %h", miso1, 64'h0); else passed++;
        step();
        total++; if (err1 !== 1'b0) $display("FAIL t5_err_one_cycle: got %b expected 0", err1); else passed++;
        addr = 29'd5; rd1 = 8'hFF;
        step();
        rd1 = 8'h00;
        step();
        total++; if (miso1 !== 64'h11223344556677AA) $display("FAIL t5_array_unchanged: got %h expected %h", miso1, 64'h11223344556677AA); else passed++;
    endtask

    task automatic test_clk_en();
        addr = 29'd5; rd1 = 8'h0F;
        step();
        rd1 = 8'h00;
        clk_en = 1'b0;
        step(); step();
        total++; if (exec1 !== 1'b0) $display("FAIL ce_stall_held: got %b expected 0", exec1); else passed++;
        total++; if (miso1 !== 64'h11223344556677AA) $display("FAIL ce_miso_held: got %h expected %h", miso1, 64'h11223344556677AA); else passed++;
        clk_en = 1'b1;
        step();
        total++; if (exec1 !== 1'b1) $display("FAIL ce_release: got %b expected 1", exec1); else passed++;
        total++; if (miso1 !== 64'h00000000556677AA) $display("FAIL ce_read_data: got %h expected %h", miso1, 64'h00000000556677AA); else passed++;
    endtask

    task automatic test_reset_mid_access();
        addr = 29'd2; mosi = 64'hDEADBEEFCAFEF00D; wr3 = 8'hFF;
        step();
        wr3 = 8'h00;
        total++; if (exec3 !== 1'b0) $display("FAIL t6_stall_1: got %b expected 0", exec3); else passed++;
        step();
        total++; if (exec3 !== 1'b0) $display("FAIL t6_stall_2: got %b expected 0", exec3); else passed++;
        step();
        total++; if (exec3 !== 1'b0) $display("FAIL t6_stall_3: got %b expected 0", exec3); else passed++;
        step();
        total++; if (exec3 !== 1'b1) $display("FAIL t6_release: got %b expected 1", exec3); else passed++;
        addr = 29'd2; rd3 = 8'hFF;
        step(); step(); step();
        rd3 = 8'h00;
        total++; if (exec3 !== 1'b0) $display("FAIL t6_read_stall: got %b expected 0", exec3); else passed++;
        step();
        total++; if (miso3 !== 64'hDEADBEEFCAFEF00D) $display("FAIL t6_read_latency: got %h expected %h", miso3, 64'hDEADBEEFCAFEF00D); else passed++;
        addr = 29'd2; mosi = 64'h0102030405060708; wr3 = 8'hFF;
        step();
        wr3 = 8'h00;
        total++; if (exec3 !== 1'b0) $display("FAIL t6_in_wait: got %b expected 0", exec3); else passed++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (exec3 !== 1'b1) $display("FAIL t6_reset_release: got %b expected 1", exec3); else passed++;
        total++; if (miso3 !== 64'h0) $display("FAIL t6_reset_miso: got %h expected %h", miso3, 64'h0); else passed++;
        addr = 29'd2; rd3 = 8'hFF;
        step();
        rd3 = 8'h00;
        step(); step(); step();
        total++; if (miso3 !== 64'hDEADBEEFCAFEF00D) $display("FAIL t6_write_dropped: got %h expected %h", miso3, 64'hDEADBEEFCAFEF00D); else passed++;
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1;
        addr = '0; mosi = '0;
        wr0 = '0; rd0 = '0; wr1 = '0; rd1 = '0; wr3 = '0; rd3 = '0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_back_to_back();
        test_out_of_window();
        test_clk_en();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
